// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sizing constants and operation decode for ram_1kx8
package ram_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  // wr only matters while selected, so it is masked into the low bit
  function automatic logic [1:0] op_decode(input logic select, input logic wr);
    return {select, select & wr};
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - plain storage, synchronous write, combinational read, no reset
module ram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ram_1kx8.sv
// rtl/ram_1kx8.sv - 1024x8 single-port RAM with registered read and per-word written flags
module ram_1kx8
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              select,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [1:0]        op;
  logic              array_we;
  logic [DATA_W-1:0] array_rdata;

  logic [DEPTH-1:0]  written_q, written_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  assign op = op_decode(select, wr);

  // Writes sampled while reset is held must not reach the array
  assign array_we = (op == OP_WRITE) && rst_n;

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (array_we),
    .addr (addr),
    .wdata(din),
    .rdata(array_rdata)
  );

  always_comb begin
    written_d    = written_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    case (op)
      OP_WRITE: written_d[addr] = 1'b1;
      OP_READ: begin
        dout_d       = written_q[addr] ? array_rdata : '0;
        dout_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      written_q    <= written_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ram_1kx8.sv
// tb/tb_ram_1kx8.sv - scoreboard bench for ram_1kx8
module tb_ram_1kx8;

  logic       clk;
  logic       rst_n;
  logic       select;
  logic       wr;
  logic [9:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;

  int total;
  int bad;
  logic [7:0] sb_q[$];

  ram_1kx8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .wr        (wr),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request for one edge; read expectations enter the scoreboard here
  task automatic issue(input logic s, input logic w, input logic [9:0] a,
                       input logic [7:0] d, input logic [7:0] exp);
    @(negedge clk);
    select = s;
    wr     = w;
    addr   = a;
    din    = d;
    if (s && !w) sb_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n  = 1'b0;
    select = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    din    = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dout !== 8'h00 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state dout=%0h valid=%0b expected dout=0 valid=0", dout, dout_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 10'd5, 8'h00, 8'h00);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_unwritten dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
  endtask

  task automatic test_fill();
    logic [7:0] e;
    for (int k = 0; k < 1024; k++) begin
      issue(1'b1, 1'b1, 10'(k), 8'((2 * k) % 256), 8'h00);
      if (k == 0) begin
        total++;
        if (dout_valid !== 1'b0) begin
          bad++;
          $display("FAIL fill_write_valid valid=%0b expected 0", dout_valid);
        end
      end
    end
    for (int k = 0; k < 1024; k++) begin
      issue(1'b1, 1'b0, 10'(k), 8'h00, 8'((2 * k) % 256));
      e = sb_q.pop_front();
      total++;
      if (dout !== e || dout_valid !== 1'b1) begin
        bad++;
        $display("FAIL fill_read addr=%0d dout=%0h valid=%0b expected dout=%0h valid=1", k, dout, dout_valid, e);
      end
    end
  endtask

  task automatic test_random_reads();
    logic [7:0]  e;
    logic [9:0]  a;
    int unsigned r;
    r = $urandom(35);
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      a = 10'(r % 1024);
      issue(1'b1, 1'b0, a, 8'h00, 8'((2 * int'(a)) % 256));
      e = sb_q.pop_front();
      total++;
      if (dout !== e || dout_valid !== 1'b1) begin
        bad++;
        $display("FAIL rand_read addr=%0d dout=%0h valid=%0b expected dout=%0h valid=1", a, dout, dout_valid, e);
      end
    end
  endtask

  task automatic test_unwritten();
    logic [7:0] e;
    pulse_reset();
    issue(1'b1, 1'b0, 10'd5, 8'h00, 8'h00);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL unwritten_after_reset dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
    issue(1'b1, 1'b1, 10'd5, 8'hA5, 8'h00);
    issue(1'b1, 1'b0, 10'd5, 8'h00, 8'hA5);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL written_a5 dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
    pulse_reset();
    issue(1'b1, 1'b0, 10'd5, 8'h00, 8'h00);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL cleared_by_reset dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
  endtask

  task automatic test_deselect();
    logic [7:0] e;
    issue(1'b1, 1'b1, 10'd8, 8'h5A, 8'h00);
    issue(1'b1, 1'b0, 10'd8, 8'h00, 8'h5A);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL desel_setup dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, 10'd7, 8'h3C, 8'h00);
      total++;
      if (dout !== 8'h5A || dout_valid !== 1'b0) begin
        bad++;
        $display("FAIL desel_idle cyc=%0d dout=%0h valid=%0b expected dout=5a valid=0", i, dout, dout_valid);
      end
    end
    issue(1'b1, 1'b0, 10'd7, 8'h00, 8'h00);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL desel_no_write dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
  endtask

  task automatic test_write_read_same();
    logic [7:0] e;
    issue(1'b1, 1'b1, 10'h3FF, 8'h11, 8'h00);
    issue(1'b1, 1'b0, 10'h3FF, 8'h00, 8'h11);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL wr_rd_same dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
    issue(1'b1, 1'b1, 10'h3FF, 8'h22, 8'h00);
    issue(1'b1, 1'b0, 10'h3FF, 8'h00, 8'h22);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL overwrite dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] e;
    issue(1'b1, 1'b1, 10'd10, 8'd20, 8'h00);
    issue(1'b1, 1'b0, 10'd10, 8'h00, 8'd20);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrd_pre dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
    #1;
    rst_n  = 1'b0;
    select = 1'b1;
    wr     = 1'b1;
    din    = 8'h77;
    #1;
    total++;
    if (dout !== 8'h00 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrd_async dout=%0h valid=%0b expected dout=0 valid=0", dout, dout_valid);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n  = 1'b1;
    select = 1'b0;
    issue(1'b0, 1'b0, 10'd10, 8'h00, 8'h00);
    total++;
    if (dout !== 8'h00 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrd_hold dout=%0h valid=%0b expected dout=0 valid=0", dout, dout_valid);
    end
    issue(1'b1, 1'b0, 10'd10, 8'h00, 8'h00);
    e = sb_q.pop_front();
    total++;
    if (dout !== e || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrd_post dout=%0h valid=%0b expected dout=%0h valid=1", dout, dout_valid, e);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_random_reads();
    test_unwritten();
    test_deselect();
    test_write_read_same();
    test_reset_mid_read();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover size=%0d expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
